lfsr_ctrl: RTL and testbench

Sequencer for the 4-bit `lfsr_struct` shift register. On a start request it loads a seed through the LFSR's `sel`/`seed` ports, then free-runs the register and watches `state` until the seed recurs. It reports the measured period, or a timeout if the seed does not recur within a step budget. It sits between test/control logic and one `lfsr_struct` instance and is the only driver of that instance's `seed` and `sel`.

---
 rtl/lfsr_ctrl.sv | 134 +++++++++++++
 tb/tb_lfsr_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_ctrl.sv
// Sequencer that seeds a 4-bit lfsr_struct, free-runs it and measures the seed recurrence period.
// Optional `LFSR_CTRL_ZERO_SEED_CHK_EN rejects an all-zero seed with an err pulse instead of running it.
module lfsr_ctrl #(
    parameter int unsigned MAX_STEPS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] seed_in,
    input  logic [3:0] lfsr_state,
    output logic [3:0] lfsr_seed,
    output logic       lfsr_sel,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [4:0] period,
    output logic       err
);

    localparam int unsigned SEED_W = 4;
    localparam int unsigned CNT_W  = 5;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [SEED_W-1:0]   seed_q, seed_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    period_q, period_d;
    logic                timeout_q, timeout_d;
    logic                sel_q, sel_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                zero_rej_c;
    logic                match_c;

`ifdef LFSR_CTRL_ZERO_SEED_CHK_EN
    assign zero_rej_c = (seed_in == '0);
`else
    assign zero_rej_c = 1'b0;
`endif

    // Count 0 is the load cycle itself, where the register trivially equals the seed.
    assign match_c = (count_q != '0) && (lfsr_state == seed_q);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        seed_d    = seed_q;
        count_d   = count_q;
        period_d  = period_q;
        timeout_d = timeout_q;
        err_d     = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (zero_rej_c) begin
                            err_d = 1'b1;
                        end else begin
                            state_d   = S_LOAD;
                            seed_d    = seed_in;
                            count_d   = '0;
                            period_d  = '0;
                            timeout_d = 1'b0;
                        end
                    end
                end
                S_LOAD: state_d = S_RUN;
                S_RUN: begin
                    if (match_c) begin
                        period_d = count_q;
                        state_d  = S_DONE;
                    end else if (count_q == MAX_CNT) begin
                        timeout_d = 1'b1;
                        period_d  = MAX_CNT;
                        state_d   = S_DONE;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        sel_d  = (state_d == S_LOAD);
        busy_d = (state_d == S_LOAD) || (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            seed_q    <= '0;
            count_q   <= '0;
            period_q  <= '0;
            timeout_q <= 1'b0;
            sel_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            seed_q    <= seed_d;
            count_q   <= count_d;
            period_q  <= period_d;
            timeout_q <= timeout_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign lfsr_seed = seed_q;
    assign lfsr_sel  = sel_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign period    = period_q;
    assign err       = err_q;

endmodule

// File: tb/tb_lfsr_ctrl.sv
// Bench for lfsr_ctrl: two instances (budget 16 and 8) each driving a behavioural 4-bit LFSR,
// checked against an arithmetic recurrence model. Honors `LFSR_CTRL_ZERO_SEED_CHK_EN.
module tb_lfsr_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic       abort = 1'b0;
    logic       abort2 = 1'b0;
    logic [3:0] seed_in = 4'h0;

    logic [3:0] lfsr1 = 4'h0;
    logic [3:0] lfsr2 = 4'h0;
    logic [3:0] lseed1, lseed2;
    logic       sel1, sel2, busy1, busy2, done1, done2, to1, to2, err1, err2;
    logic [4:0] per1, per2;

    int total = 0;
    int bad = 0;
    int sel_cnt = 0;
    logic [4:0] last_p = 5'd0;
    logic       last_to = 1'b0;

    always #5 clk = ~clk;

    lfsr_ctrl #(.MAX_STEPS(16)) u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .seed_in(seed_in), .lfsr_state(lfsr1),
        .lfsr_seed(lseed1), .lfsr_sel(sel1), .busy(busy1), .done(done1),
        .timeout(to1), .period(per1), .err(err1)
    );

    lfsr_ctrl #(.MAX_STEPS(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start2), .abort(abort2),
        .seed_in(seed_in), .lfsr_state(lfsr2),
        .lfsr_seed(lseed2), .lfsr_sel(sel2), .busy(busy2), .done(done2),
        .timeout(to2), .period(per2), .err(err2)
    );

    function automatic logic [3:0] lfsr_next(input logic [3:0] x);
        return {x[2:0], x[3] ^ x[2]};
    endfunction

    // Stand-ins for lfsr_struct; their state is deliberately not reset.
    always @(posedge clk) lfsr1 <= sel1 ? lseed1 : lfsr_next(lfsr1);
    always @(posedge clk) lfsr2 <= sel2 ? lseed2 : lfsr_next(lfsr2);

    always @(negedge clk) if (sel1) sel_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Smallest k in 1..max with step^k(s)==s; otherwise a timeout at max.
    function automatic int ref_period(input logic [3:0] s, input int max, output bit to);
        logic [3:0] x;
        x = s;
        for (int k = 1; k <= max; k++) begin
            x = lfsr_next(x);
            if (x == s) begin
                to = 1'b0;
                return k;
            end
        end
        to = 1'b1;
        return max;
    endfunction

    // Called at a negedge while both controllers are idle.
    task automatic run_measure(input logic [3:0] s, input bit keep, input bit use2);
        int p1, p2;
        bit t1, t2;
        bit seen1, seen2;
        p1 = ref_period(s, 16, t1);
        p2 = ref_period(s, 8, t2);
        seen1 = 1'b0;
        seen2 = 1'b0;
        seed_in = s;
        start = 1'b1;
        start2 = use2;
        sel_cnt = 0;
`ifdef LFSR_CTRL_ZERO_SEED_CHK_EN
        if (s == 4'h0) begin
            @(negedge clk);
            start = 1'b0;
            start2 = 1'b0;
            check("zero_err", err1, 1);
            check("zero_busy", busy1, 0);
            check("zero_period", per1, last_p);
            check("zero_timeout", to1, last_to);
            @(negedge clk);
            check("zero_err_pulse", err1, 0);
            check("zero_busy2", busy1, 0);
            check("zero_done", done1, 0);
            return;
        end
`endif
        for (int i = 1; i <= 40 && !(seen1 && (seen2 || !use2)); i++) begin
            @(negedge clk);
            if (i == 1) begin
                if (!keep) start = 1'b0;
                start2 = 1'b0;
                check("load_sel", sel1, 1);
                check("load_busy", busy1, 1);
            end
            if (i == 3) begin
                check("run_sel", sel1, 0);
                check("run_busy", busy1, 1);
            end
            if (use2 && !seen2 && done2) begin
                seen2 = 1'b1;
                check("lat8", i - 1, p2 + 2);
                check("period8", per2, p2);
                check("timeout8", to2, t2);
            end
            if (!seen1 && done1) begin
                seen1 = 1'b1;
                check("latency", i - 1, p1 + 2);
                check("period", per1, p1);
                check("timeout", to1, t1);
                check("sel_once", sel_cnt, 1);
                check("done_busy", busy1, 0);
            end
        end
        if (!seen1) check("done_seen", 0, 1);
        if (use2 && !seen2) check("done8_seen", 0, 1);
        last_p = 5'(p1);
        last_to = t1;
    endtask

    // Abort when the running count equals k (negedge after E(k+1)).
    task automatic run_abort(input logic [3:0] s, input int k);
        int dcnt;
        dcnt = 0;
        seed_in = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (k + 1) @(negedge clk);
        check("pre_abort_busy", busy1, 1);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("abort_busy", busy1, 0);
        check("abort_sel", sel1, 0);
        check("abort_done", done1, 0);
        check("abort_period", per1, 0);
        check("abort_timeout", to1, 0);
        abort = 1'b0;
        start = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done1 || busy1) dcnt++;
        end
        check("abort_quiet", dcnt, 0);
        last_p = 5'd0;
        last_to = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_seed"}, lseed1, 0);
        check({tag, "_sel"}, sel1, 0);
        check({tag, "_busy"}, busy1, 0);
        check({tag, "_done"}, done1, 0);
        check({tag, "_timeout"}, to1, 0);
        check({tag, "_period"}, per1, 0);
        check({tag, "_err"}, err1, 0);
        check({tag, "_err8"}, err2, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rs;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);

        run_measure(4'hF, 1'b0, 1'b1);
        @(negedge clk);
        check("done_pulse", done1, 0);
        check("period_held", per1, 15);

        run_measure(4'hA, 1'b1, 1'b0);
        seed_in = 4'h9;
        @(negedge clk);
        check("b2b_idle_busy", busy1, 0);
        check("b2b_idle_done", done1, 0);
        run_measure(4'h9, 1'b0, 1'b0);
        @(negedge clk);

        run_abort(4'hC, 3);

        run_measure(4'h0, 1'b0, 1'b1);
        @(negedge clk);

        seed_in = 4'h5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_vals("midrun");
        @(negedge clk);
        reset = 1'b0;
        last_p = 5'd0;
        last_to = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 20; n++) begin
            rs = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0 && rs != 4'h0)
                run_abort(rs, int'($urandom_range(1, 13)));
            else
                run_measure(rs, 1'b0, 1'b1);
            repeat (int'($urandom_range(1, 3))) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
